// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, instruction field positions
// and the memory-port FSM state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_branch_or_jump(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_J);
    endfunction

    function automatic logic is_shift_funct(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) && ((fn == FN_SLL) || (fn == FN_SRL));
    endfunction

    function automatic logic is_arith_funct(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT) || (fn == OP_ADDI);
    endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational field slicer from the instruction register to decode outputs.
module ir_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  op_code,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm16
);

    assign op_code = instr[OP_HI:OP_LO];
    assign rs      = instr[RS_HI:RS_LO];
    assign rt      = instr[RT_HI:RT_LO];
    assign rd      = instr[RD_HI:RD_LO];
    assign shamt   = instr[SH_HI:SH_LO];
    assign funct   = instr[FN_HI:FN_LO];
    assign imm16   = instr[IMM_HI:IMM_LO];

endmodule

// File: rtl/mem_port_unit.sv
// Memory-access stage: issues req/gnt/rvalid transactions for the multi-cycle
// controller, owns IR and MDR, and stalls the controller until each access ends.
module mem_port_unit
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] Instr,
    output logic [5:0]        OpCode,
    output logic [5:0]        Funct,
    output logic [4:0]        Rs,
    output logic [4:0]        Rt,
    output logic [4:0]        Rd,
    output logic [4:0]        Shamt,
    output logic [15:0]       Imm16,
    output logic [DATA_W-1:0] MemData,
    output logic              Stall,
    output logic              BusErr
);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              dst_q;
    logic [DATA_W-1:0] ir_q, mdr_q;

    logic              acc, illegal, misaligned, legal, timeout;
    logic [DATA_W-1:0] sel_addr;
    logic              launch, drop_req, load_rd, set_err, cnt_en;

    assign acc        = MemRead | MemWrite;
    assign sel_addr   = IorD ? ALUOut : PC;
    assign illegal    = MemRead & MemWrite;
    assign misaligned = |sel_addr[1:0];
    assign legal      = ~illegal & ~misaligned;
    assign timeout    = (cnt_q == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // A write completing on the last allowed cycle wins over the timeout;
    // a read granted on that cycle still aborts because its data is outstanding.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (acc) state_d = legal ? ST_REQ : ST_DONE;
            ST_REQ: begin
                if (mem_gnt && mem_we) state_d = ST_DONE;
                else if (timeout)      state_d = ST_DONE;
                else if (mem_gnt)      state_d = ST_WAIT;
            end
            ST_WAIT: if (mem_rvalid || timeout) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        launch   = 1'b0;
        drop_req = 1'b0;
        load_rd  = 1'b0;
        set_err  = 1'b0;
        cnt_en   = 1'b0;
        Stall    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                launch  = acc & legal;
                set_err = acc & ~legal;
                Stall   = acc & legal;
            end
            ST_REQ: begin
                drop_req = mem_gnt | timeout;
                set_err  = timeout & ~(mem_gnt & mem_we);
                cnt_en   = 1'b1;
                Stall    = 1'b1;
            end
            ST_WAIT: begin
                load_rd = mem_rvalid;
                set_err = timeout & ~mem_rvalid;
                cnt_en  = 1'b1;
                Stall   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dst_q     <= 1'b0;
            cnt_q     <= '0;
            ir_q      <= '0;
            mdr_q     <= '0;
            BusErr    <= 1'b0;
        end else begin
            if (launch) begin
                mem_req   <= 1'b1;
                mem_we    <= MemWrite;
                mem_addr  <= sel_addr;
                mem_wdata <= WriteData;
                dst_q     <= IRWrite;
            end else if (drop_req) begin
                mem_req <= 1'b0;
            end
            if (launch)      cnt_q <= '0;
            else if (cnt_en) cnt_q <= cnt_q + 1'b1;
            if (load_rd &&  dst_q) ir_q  <= mem_rdata;
            if (load_rd && !dst_q) mdr_q <= mem_rdata;
            if (set_err) BusErr <= 1'b1;
        end
    end

    assign Instr   = ir_q;
    assign MemData = mdr_q;

    ir_decode u_ir_decode (
        .instr   (ir_q[31:0]),
        .op_code (OpCode),
        .funct   (Funct),
        .rs      (Rs),
        .rt      (Rt),
        .rd      (Rd),
        .shamt   (Shamt),
        .imm16   (Imm16)
    );

endmodule

// File: tb/tb_mem_port_unit.sv
// Directed bench for mem_port_unit: fetch, load, store, timeout, illegal
// requests and reset during an outstanding read.
module tb_mem_port_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0, IorD = 1'b0, IRWrite = 1'b0;
    logic [31:0] PC = '0, ALUOut = '0, WriteData = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] Instr, MemData;
    logic [5:0]  OpCode, Funct;
    logic [4:0]  Rs, Rt, Rd, Shamt;
    logic [15:0] Imm16;
    logic        Stall, BusErr;

    int checks = 0;
    int errors = 0;

    mem_port_unit #(.DATA_W(32), .MAX_WAIT(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .Instr(Instr), .OpCode(OpCode), .Funct(Funct), .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .Shamt(Shamt), .Imm16(Imm16), .MemData(MemData), .Stall(Stall), .BusErr(BusErr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Inputs for the access are set by the caller at a falling edge; cycle k = 0
    // is that falling edge. gnt/rvalid fire at the given k (-1 = never).
    task automatic run_access(input int gnt_at, input int rv_at,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              input logic exp_we,
                              output int stalls, output int reqs, output int bad);
        bit done = 1'b0;
        stalls = 0; reqs = 0; bad = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            mem_gnt    = (k == gnt_at);
            mem_rvalid = (k == rv_at);
            #1;
            if (Stall) stalls++;
            if (mem_req) begin
                reqs++;
                if (mem_addr !== exp_addr || mem_wdata !== exp_wdata || mem_we !== exp_we) bad++;
            end
            if (k > 0 && !Stall) begin
                done = 1'b1;
                MemRead = 1'b0; MemWrite = 1'b0;
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end
            @(negedge clk);
        end
        check("access_completed", 32'(done), 32'd1);
    endtask

    int st, rq, bd;

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_memdata", MemData, 32'h0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_buserr", 32'(BusErr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1. Instruction fetch
        PC = 32'h0040_0000; IorD = 1'b0; IRWrite = 1'b1; MemRead = 1'b1; WriteData = 32'h0;
        mem_rdata = 32'h2009_0005;
        run_access(1, 2, 32'h0040_0000, 32'h0, 1'b0, st, rq, bd);
        check("fetch_stall_cycles", 32'(st), 32'd3);
        check("fetch_req_cycles", 32'(rq), 32'd1);
        check("fetch_req_fields", 32'(bd), 32'd0);
        check("fetch_instr", Instr, 32'h2009_0005);
        check("fetch_opcode", 32'(OpCode), 32'h08);
        check("fetch_rs", 32'(Rs), 32'd0);
        check("fetch_rt", 32'(Rt), 32'd9);
        check("fetch_imm16", 32'(Imm16), 32'h0005);
        check("fetch_mdr_untouched", MemData, 32'h0);

        // 2. Load word into MDR, one extra wait cycle before rvalid
        ALUOut = 32'h1000_0004; IorD = 1'b1; IRWrite = 1'b0; MemRead = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        run_access(1, 3, 32'h1000_0004, 32'h0, 1'b0, st, rq, bd);
        check("lw_stall_cycles", 32'(st), 32'd4);
        check("lw_req_fields", 32'(bd), 32'd0);
        check("lw_memdata", MemData, 32'hDEAD_BEEF);
        check("lw_ir_unchanged", Instr, 32'h2009_0005);

        // 3. Store word, grant on the fourth request cycle
        ALUOut = 32'h1000_0008; IorD = 1'b1; WriteData = 32'h1234_5678; MemWrite = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        run_access(4, -1, 32'h1000_0008, 32'h1234_5678, 1'b1, st, rq, bd);
        check("sw_req_cycles", 32'(rq), 32'd4);
        check("sw_req_stable", 32'(bd), 32'd0);
        check("sw_stall_no_wait", 32'(st), 32'd5);
        check("sw_mdr_unchanged", MemData, 32'hDEAD_BEEF);
        check("sw_buserr", 32'(BusErr), 32'd0);

        // 4. No grant: abort after 15 cycles in REQ
        PC = 32'h0040_0004; IorD = 1'b0; IRWrite = 1'b1; MemRead = 1'b1;
        run_access(-1, -1, 32'h0040_0004, 32'h1234_5678, 1'b0, st, rq, bd);
        check("to_req_cycles", 32'(rq), 32'd15);
        check("to_stall_cycles", 32'(st), 32'd16);
        check("to_buserr", 32'(BusErr), 32'd1);
        check("to_mem_req", 32'(mem_req), 32'd0);
        check("to_ir_unchanged", Instr, 32'h2009_0005);
        check("to_mdr_unchanged", MemData, 32'hDEAD_BEEF);

        PC = 32'h0040_0008; IorD = 1'b0; IRWrite = 1'b1; MemRead = 1'b1;
        mem_rdata = 32'h8C08_0004;
        run_access(1, 2, 32'h0040_0008, 32'h1234_5678, 1'b0, st, rq, bd);
        check("after_to_stall_cycles", 32'(st), 32'd3);
        check("after_to_instr", Instr, 32'h8C08_0004);
        check("after_to_opcode", 32'(OpCode), 32'h23);
        check("after_to_is_mem", 32'(is_mem_op(OpCode)), 32'd1);
        check("after_to_rt", 32'(Rt), 32'd8);
        check("after_to_buserr_sticky", 32'(BusErr), 32'd1);

        // 5a. Misaligned data address
        pulse_reset();
        ALUOut = 32'h1000_0002; IorD = 1'b1; IRWrite = 1'b0; MemRead = 1'b1;
        #1;
        check("mis_stall_idle", 32'(Stall), 32'd0);
        run_access(-1, -1, 32'h0, 32'h0, 1'b0, st, rq, bd);
        check("mis_req_cycles", 32'(rq), 32'd0);
        check("mis_stall_cycles", 32'(st), 32'd0);
        check("mis_buserr", 32'(BusErr), 32'd1);

        // 5b. Read and write together
        pulse_reset();
        ALUOut = 32'h1000_0000; IorD = 1'b1; MemRead = 1'b1; MemWrite = 1'b1;
        run_access(-1, -1, 32'h0, 32'h0, 1'b0, st, rq, bd);
        check("rw_req_cycles", 32'(rq), 32'd0);
        check("rw_stall_cycles", 32'(st), 32'd0);
        check("rw_buserr", 32'(BusErr), 32'd1);

        // 6. Reset while a read is waiting for data
        pulse_reset();
        PC = 32'h0040_0000; IorD = 1'b0; IRWrite = 1'b1; MemRead = 1'b1; WriteData = 32'h0;
        mem_rdata = 32'h2009_0005;
        run_access(1, 2, 32'h0040_0000, 32'h0, 1'b0, st, rq, bd);
        check("pre_rst_instr", Instr, 32'h2009_0005);
        PC = 32'h0040_0004; MemRead = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("wait_stall", 32'(Stall), 32'd1);
        MemRead = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_instr", Instr, 32'h0);
        check("midrst_stall", 32'(Stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_rdata = 32'hFFFF_FFFF;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("late_rvalid_instr", Instr, 32'h0);
        check("late_rvalid_mdr", MemData, 32'h0);
        check("late_rvalid_stall", 32'(Stall), 32'd0);
        check("late_rvalid_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        PC = 32'h0040_000C; MemRead = 1'b1; IRWrite = 1'b1;
        mem_rdata = 32'h0128_5020;
        run_access(1, 2, 32'h0040_000C, 32'h0, 1'b0, st, rq, bd);
        check("post_rst_stall_cycles", 32'(st), 32'd3);
        check("post_rst_instr", Instr, 32'h0128_5020);
        check("post_rst_rd", 32'(Rd), 32'd10);
        check("post_rst_funct", 32'(Funct), 32'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
